// File: rtl/alu_pkg.sv
// Shared widths, ALU opcode constants and sequencer state encoding.
// The optional divide-by-zero trap is enabled with ALU_DIV0_TRAP_EN.
package alu_pkg;

  localparam int DW   = 8;
  localparam int NREG = 4;
  localparam int RAW  = $clog2(NREG);

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_MUL  = 4'd2;
  localparam logic [3:0] OP_DIV  = 4'd3;
  localparam logic [3:0] OP_MOD  = 4'd4;
  localparam logic [3:0] OP_LAND = 4'd5;
  localparam logic [3:0] OP_LOR  = 4'd6;
  localparam logic [3:0] OP_LNOT = 4'd7;
  localparam logic [3:0] OP_AND  = 4'd8;
  localparam logic [3:0] OP_OR   = 4'd9;
  localparam logic [3:0] OP_XOR  = 4'd10;
  localparam logic [3:0] OP_NOT  = 4'd11;
  localparam logic [3:0] OP_SHL  = 4'd12;
  localparam logic [3:0] OP_SHR  = 4'd13;
  localparam logic [3:0] OP_INC  = 4'd14;
  localparam logic [3:0] OP_DEC  = 4'd15;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

endpackage

// File: rtl/alu_regfile.sv
// NREG x DW register file: two asynchronous read ports, one synchronous
// write port, asynchronous reset of every entry to zero.
module alu_regfile
  import alu_pkg::*;
(
  input  logic           clk,
  input  logic           rst,
  input  logic [RAW-1:0] raddr_a,
  input  logic [RAW-1:0] raddr_b,
  output logic [DW-1:0]  rdata_a,
  output logic [DW-1:0]  rdata_b,
  input  logic           we,
  input  logic [RAW-1:0] waddr,
  input  logic [DW-1:0]  wdata
);

  logic [DW-1:0] regs [NREG];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
    end else if (we) begin
      regs[waddr] <= wdata;
    end
  end

  assign rdata_a = regs[raddr_a];
  assign rdata_b = regs[raddr_b];

endmodule

// File: rtl/alu_op_sequencer.sv
// Serial command sequencer in front of the 8-bit combinational ALU.
// Build option ALU_DIV0_TRAP_EN adds the err port and the div/mod-by-zero trap.
//
// Handshakes: a transfer happens on a rising edge where valid && ready are
// both high. cmd_ready is high only in IDLE; res_valid rises entering RESP and
// holds res_data/res_dst stable until the edge that sees res_ready high.
module alu_op_sequencer
  import alu_pkg::*;
(
  input  logic           clk,
  input  logic           rst,
  input  logic           cmd_valid,
  output logic           cmd_ready,
  input  logic [3:0]     cmd_opcode,
  input  logic [RAW-1:0] cmd_dst,
  input  logic [RAW-1:0] cmd_srca,
  input  logic [RAW-1:0] cmd_srcb,
  input  logic           cmd_imm_sel,
  input  logic [DW-1:0]  cmd_imm,
  output logic [DW-1:0]  a,
  output logic [DW-1:0]  b,
  output logic [3:0]     opcode,
  input  logic [DW-1:0]  op,
  output logic           res_valid,
  input  logic           res_ready,
  output logic [DW-1:0]  res_data,
  output logic [RAW-1:0] res_dst,
  output logic [1:0]     state_dbg
`ifdef ALU_DIV0_TRAP_EN
  ,
  output logic           err
`endif
);

  state_t         state, state_nxt;
  logic [RAW-1:0] dst_q;
  logic [DW-1:0]  rdata_a, rdata_b;
  logic           reg_we;
  logic           trap;

  alu_regfile u_regfile (
    .clk     (clk),
    .rst     (rst),
    .raddr_a (cmd_srca),
    .raddr_b (cmd_srcb),
    .rdata_a (rdata_a),
    .rdata_b (rdata_b),
    .we      (reg_we),
    .waddr   (dst_q),
    .wdata   (op)
  );

`ifdef ALU_DIV0_TRAP_EN
  assign trap = (state == EXEC) && ((opcode == OP_DIV) || (opcode == OP_MOD)) && (b == '0);
`else
  assign trap = 1'b0;
`endif

  assign state_dbg = state;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    cmd_ready = 1'b0;
    reg_we    = 1'b0;
    case (state)
      IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) state_nxt = EXEC;
      end
      EXEC: begin
        reg_we    = !trap;
        state_nxt = RESP;
      end
      RESP: begin
        if (res_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Operands are read at accept, so a same-register dst sees the old value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a         <= '0;
      b         <= '0;
      opcode    <= '0;
      dst_q     <= '0;
      res_data  <= '0;
      res_dst   <= '0;
      res_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            a      <= rdata_a;
            b      <= cmd_imm_sel ? cmd_imm : rdata_b;
            opcode <= cmd_opcode;
            dst_q  <= cmd_dst;
          end
        end
        EXEC: begin
          res_data  <= trap ? '0 : op;
          res_dst   <= dst_q;
          res_valid <= 1'b1;
        end
        RESP: begin
          if (res_ready) res_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

`ifdef ALU_DIV0_TRAP_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) err <= 1'b0;
    else     err <= trap;
  end
`endif

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed bench for alu_op_sequencer with a behavioural ALU on a/b/opcode.
// Define ALU_DIV0_TRAP_EN to also cover the divide-by-zero trap.
module tb_alu_op_sequencer;

  logic       clk;
  logic       rst;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [3:0] cmd_opcode;
  logic [1:0] cmd_dst;
  logic [1:0] cmd_srca;
  logic [1:0] cmd_srcb;
  logic       cmd_imm_sel;
  logic [7:0] cmd_imm;
  logic [7:0] a;
  logic [7:0] b;
  logic [3:0] opcode;
  logic [7:0] op;
  logic       res_valid;
  logic       res_ready;
  logic [7:0] res_data;
  logic [1:0] res_dst;
  logic [1:0] state_dbg;
`ifdef ALU_DIV0_TRAP_EN
  logic       err;
`endif

  int n_checks = 0;
  int n_errors = 0;
  logic [7:0] exp_q[$];

  alu_op_sequencer dut (
    .clk         (clk),
    .rst         (rst),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_opcode  (cmd_opcode),
    .cmd_dst     (cmd_dst),
    .cmd_srca    (cmd_srca),
    .cmd_srcb    (cmd_srcb),
    .cmd_imm_sel (cmd_imm_sel),
    .cmd_imm     (cmd_imm),
    .a           (a),
    .b           (b),
    .opcode      (opcode),
    .op          (op),
    .res_valid   (res_valid),
    .res_ready   (res_ready),
    .res_data    (res_data),
    .res_dst     (res_dst),
    .state_dbg   (state_dbg)
`ifdef ALU_DIV0_TRAP_EN
    ,
    .err         (err)
`endif
  );

  // Behavioural stand-in for the combinational ALU.
  always_comb begin
    op = 8'h00;
    case (opcode)
      4'd0:  op = a + b;
      4'd1:  op = a - b;
      4'd2:  op = a * b;
      4'd3:  op = (b != 0) ? a / b : 8'h00;
      4'd4:  op = (b != 0) ? a % b : 8'h00;
      4'd5:  op = {7'd0, (a != 0) && (b != 0)};
      4'd6:  op = {7'd0, (a != 0) || (b != 0)};
      4'd7:  op = {7'd0, (a == 0)};
      4'd8:  op = a & b;
      4'd9:  op = a | b;
      4'd10: op = a ^ b;
      4'd11: op = ~a;
      4'd12: op = a << 1;
      4'd13: op = a >> 1;
      4'd14: op = a + 8'd1;
      default: op = a - 8'd1;
    endcase
  end

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic drive_cmd(input logic [3:0] opc, input logic [1:0] dst, input logic [1:0] sa,
                           input logic [1:0] sb, input logic isel, input logic [7:0] imm);
    cmd_opcode  = opc;
    cmd_dst     = dst;
    cmd_srca    = sa;
    cmd_srcb    = sb;
    cmd_imm_sel = isel;
    cmd_imm     = imm;
    cmd_valid   = 1'b1;
  endtask

  // Full command: accept, check ALU inputs in EXEC, check result in RESP, handshake.
  task automatic run_cmd(input string tag, input logic [3:0] opc, input logic [1:0] dst,
                         input logic [1:0] sa, input logic [1:0] sb, input logic isel,
                         input logic [7:0] imm, input logic [7:0] exp_a, input logic [7:0] exp_b,
                         input logic [7:0] exp_res, input logic exp_err);
    logic [7:0] exp_d;
    int         n;
    @(negedge clk);
    drive_cmd(opc, dst, sa, sb, isel, imm);
    n = 0;
    while (!cmd_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_cmd_ready"}, {31'd0, cmd_ready}, 32'd1);
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    check({tag, "_exec_state"}, {30'd0, state_dbg}, 32'd1);
    check({tag, "_a"}, {24'd0, a}, {24'd0, exp_a});
    check({tag, "_b"}, {24'd0, b}, {24'd0, exp_b});
    check({tag, "_opcode"}, {28'd0, opcode}, {28'd0, opc});
    exp_q.push_back(exp_res);
    n = 0;
    while (!res_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_res_valid"}, {31'd0, res_valid}, 32'd1);
    exp_d = exp_q.pop_front();
    check({tag, "_res_data"}, {24'd0, res_data}, {24'd0, exp_d});
    check({tag, "_res_dst"}, {30'd0, res_dst}, {30'd0, dst});
`ifdef ALU_DIV0_TRAP_EN
    check({tag, "_err"}, {31'd0, err}, {31'd0, exp_err});
`endif
    res_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    res_ready = 1'b0;
    check({tag, "_res_valid_clr"}, {31'd0, res_valid}, 32'd0);
`ifdef ALU_DIV0_TRAP_EN
    check({tag, "_err_clr"}, {31'd0, err}, 32'd0);
`endif
  endtask

  initial begin
    rst       = 1'b1;
    cmd_valid = 1'b0;
    res_ready = 1'b0;
    drive_cmd(4'd0, 2'd0, 2'd0, 2'd0, 1'b0, 8'h00);
    cmd_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Reset state
    check("rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    check("rst_res_valid", {31'd0, res_valid}, 32'd0);
    check("rst_state", {30'd0, state_dbg}, 32'd0);
    check("rst_abop", {12'd0, a, b, opcode}, 32'd0);
    check("rst_res", {22'd0, res_data, res_dst}, 32'd0);

    // Immediate loads, add wrap, sub wrap
    run_cmd("add_imm", 4'd0, 2'd1, 2'd1, 2'd0, 1'b1, 8'h25, 8'h00, 8'h25, 8'h25, 1'b0);
    run_cmd("ld_r2",   4'd0, 2'd2, 2'd0, 2'd0, 1'b1, 8'hF0, 8'h00, 8'hF0, 8'hF0, 1'b0);
    run_cmd("add_wrap", 4'd0, 2'd3, 2'd1, 2'd2, 1'b0, 8'h00, 8'h25, 8'hF0, 8'h15, 1'b0);
    run_cmd("sub_wrap", 4'd1, 2'd3, 2'd3, 2'd0, 1'b1, 8'h16, 8'h15, 8'h16, 8'hFF, 1'b0);

    // Multiply truncation with srca == srcb, logical and
    run_cmd("ld_r1",   4'd0, 2'd1, 2'd0, 2'd0, 1'b1, 8'h10, 8'h00, 8'h10, 8'h10, 1'b0);
    run_cmd("mul_trunc", 4'd2, 2'd0, 2'd1, 2'd1, 1'b0, 8'h00, 8'h10, 8'h10, 8'h00, 1'b0);
    run_cmd("land",    4'd5, 2'd0, 2'd2, 2'd0, 1'b1, 8'h25, 8'hF0, 8'h25, 8'h01, 1'b0);

    // Backpressure: result held 5 cycles while a second command waits
    @(negedge clk);
    drive_cmd(4'd6, 2'd2, 2'd0, 2'd0, 1'b1, 8'h00);
    @(posedge clk);
    @(negedge clk);
    check("bp_exec_a", {24'd0, a}, 32'h01);
    drive_cmd(4'd0, 2'd1, 2'd2, 2'd0, 1'b1, 8'h02);
    check("bp_exec_not_ready", {31'd0, cmd_ready}, 32'd0);
    @(negedge clk);
    check("bp_res_valid", {31'd0, res_valid}, 32'd1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_hold_valid", {31'd0, res_valid}, 32'd1);
      check("bp_hold_data", {24'd0, res_data}, 32'h01);
      check("bp_hold_dst", {30'd0, res_dst}, 32'd2);
      check("bp_hold_not_ready", {31'd0, cmd_ready}, 32'd0);
    end
    res_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    res_ready = 1'b0;
    check("bp_hs_idle", {30'd0, state_dbg}, 32'd0);
    check("bp_hs_valid_clr", {31'd0, res_valid}, 32'd0);
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    check("bp_2nd_exec", {30'd0, state_dbg}, 32'd1);
    check("bp_2nd_a_fwd", {24'd0, a}, 32'h01);
    check("bp_2nd_b", {24'd0, b}, 32'h02);
    @(negedge clk);
    check("bp_2nd_data", {24'd0, res_data}, 32'h03);
    check("bp_2nd_dst", {30'd0, res_dst}, 32'd1);
    res_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    res_ready = 1'b0;

`ifdef ALU_DIV0_TRAP_EN
    // R0=1 R1=3 R2=1 R3=FF here
    run_cmd("clr_r3",  4'd1, 2'd3, 2'd3, 2'd3, 1'b0, 8'h00, 8'hFF, 8'hFF, 8'h00, 1'b0);
    run_cmd("ld_r1_25", 4'd0, 2'd1, 2'd3, 2'd0, 1'b1, 8'h25, 8'h00, 8'h25, 8'h25, 1'b0);
    run_cmd("div0",    4'd3, 2'd2, 2'd1, 2'd0, 1'b1, 8'h00, 8'h25, 8'h00, 8'h00, 1'b1);
    run_cmd("r2_kept", 4'd0, 2'd0, 2'd2, 2'd0, 1'b1, 8'h00, 8'h01, 8'h00, 8'h01, 1'b0);
    run_cmd("div5",    4'd3, 2'd2, 2'd1, 2'd0, 1'b1, 8'h05, 8'h25, 8'h05, 8'h07, 1'b0);
`endif

    // Reset asserted during EXEC
    @(negedge clk);
    drive_cmd(4'd0, 2'd3, 2'd1, 2'd0, 1'b1, 8'h44);
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    check("mid_exec", {30'd0, state_dbg}, 32'd1);
    rst = 1'b1;
    #1;
    check("mid_rst_abop", {12'd0, a, b, opcode}, 32'd0);
    check("mid_rst_res", {21'd0, res_valid, res_data, res_dst}, 32'd0);
    check("mid_rst_ready", {31'd0, cmd_ready}, 32'd1);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_valid", {31'd0, res_valid}, 32'd0);
    run_cmd("post_rst_rd", 4'd0, 2'd0, 2'd1, 2'd2, 1'b0, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
